// File: rtl/fetch_unit_pkg.sv
// Shared constants and slot encoding for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_FULL    = 2'd2
    } slot_state_e;

endpackage

// File: rtl/fetch_unit_buf.sv
// Circular pc/insn entry FIFO: slots are allocated at request accept, filled in
// request order by responses and popped by decode.
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [AWIDTH-1:0] alloc_pc,
    input  logic              fill,
    input  logic [DWIDTH-1:0] fill_data,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic [CW-1:0]     pending,
    output logic              head_full,
    output logic [AWIDTH-1:0] head_pc,
    output logic [DWIDTH-1:0] head_insn
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] count_q, pend_q;
    slot_state_e   state_q [DEPTH];
    logic [AWIDTH-1:0] pc_q [DEPTH];
    logic [DWIDTH-1:0] insn_q [DEPTH];

    logic do_alloc, do_fill, do_pop;

    // Slots between head and fill_ptr are FULL, fill_ptr to alloc_ptr are PENDING,
    // so the oldest PENDING slot is always at fill_ptr.
    assign do_alloc = alloc && (count_q != DEPTH_C);
    assign do_fill  = fill && (pend_q != '0);
    assign do_pop   = pop && (state_q[head_ptr] == SLOT_FULL);

    assign full      = (count_q == DEPTH_C);
    assign pending   = pend_q;
    assign head_full = (state_q[head_ptr] == SLOT_FULL);
    assign head_pc   = pc_q[head_ptr];
    assign head_insn = insn_q[head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i] <= SLOT_EMPTY;
                pc_q[i]    <= '0;
                insn_q[i]  <= '0;
            end
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i] <= SLOT_EMPTY;
            end
        end else begin
            if (do_alloc) begin
                state_q[alloc_ptr] <= SLOT_PENDING;
                pc_q[alloc_ptr]    <= alloc_pc;
                alloc_ptr          <= alloc_ptr + PW'(1);
            end
            if (do_fill) begin
                state_q[fill_ptr] <= SLOT_FULL;
                insn_q[fill_ptr]  <= fill_data;
                fill_ptr          <= fill_ptr + PW'(1);
            end
            if (do_pop) begin
                state_q[head_ptr] <= SLOT_EMPTY;
                head_ptr          <= head_ptr + PW'(1);
            end
            count_q <= count_q + CW'(do_alloc) - CW'(do_pop);
            pend_q  <= pend_q + CW'(do_alloc) - CW'(do_fill);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and presents
// {pc, insn, opcode} to decode; a redirect flushes buffered work and drops in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [AWIDTH-1:0] BASEADDR = BASEADDR_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_valid_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              f_valid_o,
    input  logic              f_ready_i,
    output logic [AWIDTH-1:0] f_pc_o,
    output logic [DWIDTH-1:0] f_insn_o,
    output logic [6:0]        f_opcode_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] pc_q;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     pending;
    logic              buf_full, head_full;
    logic [AWIDTH-1:0] head_pc;
    logic [DWIDTH-1:0] head_insn;
    logic              req_fire, rsp_drop, rsp_claim, rsp_fill;
    logic              unused_bits;

    assign unused_bits = ^redirect_pc_i[1:0];

    assign imem_req_valid_o = (state_q == ST_RUN) && !buf_full && !redirect_valid_i;
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_drop  = imem_rsp_valid_i && (drop_q != '0);
    assign rsp_claim = imem_rsp_valid_i && (drop_q == '0) && (pending != '0);
    assign rsp_fill  = rsp_claim && !redirect_valid_i;

    // A response arriving with a redirect already accounts for one pending slot.
    always_comb begin
        drop_d = drop_q;
        if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
        end
        if (redirect_valid_i) begin
            drop_d = drop_d + pending - CW'(rsp_claim);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (redirect_valid_i && (drop_d != '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (drop_d == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            pc_q    <= BASEADDR;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (redirect_valid_i) begin
                pc_q <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            end else if (req_fire) begin
                pc_q <= pc_q + AWIDTH'(4);
            end
        end
    end

    fetch_buf #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .alloc    (req_fire),
        .alloc_pc (pc_q),
        .fill     (rsp_fill),
        .fill_data(imem_rsp_data_i),
        .pop      (f_valid_o && f_ready_i),
        .flush    (redirect_valid_i),
        .full     (buf_full),
        .pending  (pending),
        .head_full(head_full),
        .head_pc  (head_pc),
        .head_insn(head_insn)
    );

    assign f_valid_o  = head_full;
    assign f_pc_o     = head_pc;
    assign f_insn_o   = head_insn;
    assign f_opcode_o = head_insn[6:0];

    a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rsp_valid_i && (drop_q == '0) && (pending == '0)))
        else $error("fetch_unit: imem response with nothing outstanding");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for steady streaming plus hand sequences
// for back-pressure, redirect draining, imem stalls and mid-stream reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_pc;
    logic [31:0] f_insn;
    logic [6:0]  f_opcode;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .DEPTH   (2),
        .BASEADDR(32'h0100_0000)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_req_valid_o(req_valid),
        .imem_req_ready_i(req_ready),
        .imem_req_addr_o (req_addr),
        .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_data_i (rsp_data),
        .redirect_valid_i(redir),
        .redirect_pc_i   (redir_pc),
        .f_valid_o       (f_valid),
        .f_ready_i       (f_ready),
        .f_pc_o          (f_pc),
        .f_insn_o        (f_insn),
        .f_opcode_o      (f_opcode)
    );

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        fr;
        logic        erv;
        logic [31:0] eaddr;
        logic        efv;
        logic [31:0] epc;
        logic [31:0] eins;
    } vec_t;

    vec_t tbl [9];

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h1234_5637;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h0040_006F;

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] data,
                                input logic fr, input logic erv, input logic [31:0] eaddr,
                                input logic efv, input logic [31:0] epc, input logic [31:0] eins);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.data = data; v.fr = fr;
        v.erv = erv; v.eaddr = eaddr; v.efv = efv; v.epc = epc; v.eins = eins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic rdir, input logic [31:0] rpc, input logic fr);
        req_ready = rdy;
        rsp_valid = rv;
        rsp_data  = rd;
        redir     = rdir;
        redir_pc  = rpc;
        f_ready   = fr;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic erv, input logic [31:0] eaddr,
                              input logic efv, input logic [31:0] epc, input logic [31:0] eins);
        logic [6:0] eop;
        eop = eins[6:0];
        chk({tag, " req_valid"}, 32'(req_valid), 32'(erv));
        if (erv) chk({tag, " req_addr"}, req_addr, eaddr);
        chk({tag, " f_valid"}, 32'(f_valid), 32'(efv));
        if (efv) begin
            chk({tag, " f_pc"}, f_pc, epc);
            chk({tag, " f_insn"}, f_insn, eins);
            chk({tag, " f_opcode"}, 32'(f_opcode), 32'(eop));
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance to the next negedge.
    task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic rdir, input logic [31:0] rpc, input logic fr,
                        input logic erv, input logic [31:0] eaddr,
                        input logic efv, input logic [31:0] epc, input logic [31:0] eins);
        drive(rdy, rv, rd, rdir, rpc, fr);
        expect_out(tag, erv, eaddr, efv, epc, eins);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst req_valid"}, 32'(req_valid), 32'd0);
        chk({tag, " rst f_valid"}, 32'(f_valid), 32'd0);
        chk({tag, " rst f_pc"}, f_pc, 32'd0);
        chk({tag, " rst f_insn"}, f_insn, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1'b1, 1'b0, '0, 1'b1, 1'b0, '0,           1'b0, '0,           '0);
        tbl[1] = mk(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0100_0000, 1'b0, '0,           '0);
        tbl[2] = mk(1'b1, 1'b1, D0, 1'b1, 1'b1, 32'h0100_0004, 1'b0, '0,           '0);
        tbl[3] = mk(1'b1, 1'b1, D1, 1'b1, 1'b0, '0,           1'b1, 32'h0100_0000, D0);
        tbl[4] = mk(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0100_0008, 1'b1, 32'h0100_0004, D1);
        tbl[5] = mk(1'b1, 1'b1, D2, 1'b1, 1'b1, 32'h0100_000C, 1'b0, '0,           '0);
        tbl[6] = mk(1'b1, 1'b1, D3, 1'b1, 1'b0, '0,           1'b1, 32'h0100_0008, D2);
        tbl[7] = mk(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_000C, D3);
        tbl[8] = mk(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0100_0010, 1'b0, '0,           '0);

        // Streaming with 1-cycle responses and decode always ready.
        do_reset("t1");
        for (int i = 0; i < 9; i++) begin
            step($sformatf("t1[%0d]", i), tbl[i].rdy, tbl[i].rsp, tbl[i].data, 1'b0, '0, tbl[i].fr,
                 tbl[i].erv, tbl[i].eaddr, tbl[i].efv, tbl[i].epc, tbl[i].eins);
        end

        // Decode stalled: buffer fills after two requests and the head is held.
        do_reset("t2");
        step("t2 boot", 1, 0, '0, 0, '0, 0, 0, '0, 0, '0, '0);
        step("t2 req0", 1, 0, '0, 0, '0, 0, 1, 32'h0100_0000, 0, '0, '0);
        step("t2 req1", 1, 1, D0, 0, '0, 0, 1, 32'h0100_0004, 0, '0, '0);
        step("t2 full", 1, 1, D1, 0, '0, 0, 0, '0, 1, 32'h0100_0000, D0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("t2 hold%0d", i), 1, 0, '0, 0, '0, 0, 0, '0, 1, 32'h0100_0000, D0);
        end
        step("t2 pop0", 1, 0, '0, 0, '0, 1, 0, '0, 1, 32'h0100_0000, D0);
        step("t2 pop1", 0, 0, '0, 0, '0, 1, 1, 32'h0100_0008, 1, 32'h0100_0004, D1);

        // Redirect with two pending: both late responses dropped, then fetch at aligned target.
        do_reset("t3");
        step("t3 boot", 1, 0, '0, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t3 req0", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0000, 0, '0, '0);
        step("t3 req1", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0004, 0, '0, '0);
        step("t3 redir", 1, 0, '0, 1, 32'h0100_0103, 1, 0, '0, 0, '0, '0);
        step("t3 drop0", 1, 1, 32'h1111_1111, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t3 drop1", 1, 1, 32'h2222_2222, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t3 resume", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0100, 0, '0, '0);
        step("t3 rsp", 0, 1, 32'hABCD_0033, 0, '0, 1, 1, 32'h0100_0104, 0, '0, '0);
        step("t3 out", 0, 0, '0, 0, '0, 1, 1, 32'h0100_0104, 1, 32'h0100_0100, 32'hABCD_0033);

        // Redirect coincident with a response: only one further response dropped.
        do_reset("t4");
        step("t4 boot", 1, 0, '0, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t4 req0", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0000, 0, '0, '0);
        step("t4 req1", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0004, 0, '0, '0);
        step("t4 redir", 1, 1, 32'h3333_3333, 1, 32'h0200_0008, 1, 0, '0, 0, '0, '0);
        step("t4 drop", 1, 1, 32'h4444_4444, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t4 resume", 1, 0, '0, 0, '0, 1, 1, 32'h0200_0008, 0, '0, '0);
        step("t4 rsp", 0, 1, 32'h5555_0063, 0, '0, 1, 1, 32'h0200_000C, 0, '0, '0);
        step("t4 out", 0, 0, '0, 0, '0, 1, 1, 32'h0200_000C, 1, 32'h0200_0008, 32'h5555_0063);

        // imem not ready: request held stable, no allocation, PC advances only once.
        do_reset("t5");
        step("t5 boot", 0, 0, '0, 0, '0, 1, 0, '0, 0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("t5 stall%0d", i), 0, 0, '0, 0, '0, 1, 1, 32'h0100_0000, 0, '0, '0);
        end
        step("t5 accept", 1, 0, '0, 0, '0, 1, 1, 32'h0100_0000, 0, '0, '0);
        step("t5 next", 0, 0, '0, 0, '0, 1, 1, 32'h0100_0004, 0, '0, '0);
        step("t5 rsp", 0, 1, D0, 0, '0, 1, 1, 32'h0100_0004, 0, '0, '0);
        step("t5 out", 0, 0, '0, 0, '0, 1, 1, 32'h0100_0004, 1, 32'h0100_0000, D0);

        // Asynchronous reset while both slots hold instructions.
        do_reset("t6");
        step("t6 boot", 1, 0, '0, 0, '0, 0, 0, '0, 0, '0, '0);
        step("t6 req0", 1, 0, '0, 0, '0, 0, 1, 32'h0100_0000, 0, '0, '0);
        step("t6 req1", 1, 1, D0, 0, '0, 0, 1, 32'h0100_0004, 0, '0, '0);
        step("t6 fill", 1, 1, D1, 0, '0, 0, 0, '0, 1, 32'h0100_0000, D0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        expect_out("t6 full", 1'b0, '0, 1'b1, 32'h0100_0000, D0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 midrst req_valid", 32'(req_valid), 32'd0);
        chk("t6 midrst f_valid", 32'(f_valid), 32'd0);
        chk("t6 midrst f_pc", f_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6 reboot", 1, 0, '0, 0, '0, 1, 0, '0, 0, '0, '0);
        step("t6 restart", 0, 0, '0, 0, '0, 1, 1, 32'h0100_0000, 0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
